restoring_divider_seq: RTL

- Sequential N-bit unsigned restoring divider that produces quotient and remainder by repeated shift-and-subtract.
- Uses one shared (N+1)-bit add/subtract stage per iteration; cin=1 selects subtract, cin=0 selects add.
- Sits in the arithmetic datapath as the inverse-operation companion to the combinational adder/subtractor.
- Start/done handshake; one quotient bit is resolved per clock.

---
 rtl/div_pkg.sv | 15 +
 rtl/restoring_divider_seq_if.sv | 25 ++
 rtl/restoring_divider_seq_addsub.sv | 19 +
 rtl/restoring_divider_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold values 0..N.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_seq_if.sv
// Start/done handshake and operand/result bundle for restoring_divider_seq.
interface restoring_divider_seq_if #(
    parameter int unsigned N = 4
) ();

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/restoring_divider_seq_addsub.sv
// W-bit add/subtract stage: sum = a + (b ^ {W{cin}}) + cin, carry-out exposed.
module addsub_stage #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] b_x;

    always_comb begin
        b_x         = b ^ {W{cin}};
        {cout, sum} = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, cin};
    end

endmodule

// File: rtl/restoring_divider_seq.sv
// Sequential N-bit unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_CHECK_EN to short-circuit divide-by-zero straight to DONE.
module restoring_divider_seq
    import div_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    restoring_divider_seq_if.slave  bus
);

    localparam int unsigned CW = cnt_width(N);

    state_t        state;
    state_t        next_state;

    logic [N-1:0]  q_reg;
    logic [N-1:0]  d_reg;
    logic [N:0]    r_reg;
    logic [CW-1:0] count;

    logic [N-1:0]  quotient_reg;
    logic [N-1:0]  remainder_reg;

    logic [N:0]    r_shift;
    logic [N:0]    t_val;
    logic          t_cout;
    logic [N:0]    r_next;
    logic [N-1:0]  q_next;
    logic          last_iter;

`ifdef DIV_ZERO_CHECK_EN
    logic          dz_reg;
    logic          zero_div;
`endif

    always_comb begin
        r_shift   = {r_reg[N-1:0], q_reg[N-1]};
        last_iter = (count == CW'(N - 1));
    end

    addsub_stage #(
        .W (N + 1)
    ) u_addsub (
        .a    (r_shift),
        .b    ({1'b0, d_reg}),
        .cin  (1'b1),
        .sum  (t_val),
        .cout (t_cout)
    );

    // T[N] set means the trial subtraction borrowed: keep the shifted remainder.
    always_comb begin
        r_next = t_val[N] ? r_shift : t_val;
        q_next = {q_reg[N-2:0], ~t_val[N]};
    end

`ifdef DIV_ZERO_CHECK_EN
    always_comb begin
        zero_div = (bus.divisor == '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef DIV_ZERO_CHECK_EN
                    next_state = zero_div ? DONE : RUN;
`else
                    next_state = RUN;
`endif
                end
            end
            RUN: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg         <= '0;
            d_reg         <= '0;
            r_reg         <= '0;
            count         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dz_reg        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        q_reg <= bus.dividend;
                        d_reg <= bus.divisor;
                        r_reg <= '0;
                        count <= '0;
`ifdef DIV_ZERO_CHECK_EN
                        if (zero_div) begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                            dz_reg        <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= r_next[N-1:0];
`ifdef DIV_ZERO_CHECK_EN
                        dz_reg        <= 1'b0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // While iterating, R < D keeps R[N] clear and makes carry-out the inverse of T[N].
    always_ff @(posedge clk) begin
        if (!rst && state == RUN) begin
            assert ((t_cout == ~t_val[N]) && !r_reg[N]);
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
`ifdef DIV_ZERO_CHECK_EN
    assign bus.div_by_zero = dz_reg;
`else
    assign bus.div_by_zero = 1'b0;
`endif

endmodule
